// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller slice.
// Contents:
//   state_e        - frame decoder states
//   REG_*          - fixed register map indices
//   CMD_WR_BIT     - command byte bit selecting write (1) or read (0)
//   TX_DISCARD     - MISO filler for frames addressing past the register file
//   addr_in_range  - true when a 7-bit start address lands inside the register file
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    localparam int unsigned REG_ID     = 32'd0;
    localparam int unsigned REG_STATUS = 32'd1;
    localparam int unsigned REG_LED    = 32'd2;
    localparam int unsigned CMD_WR_BIT = 32'd7;

    localparam logic [7:0] TX_DISCARD = 8'hFF;

    // Compared at 32 bits so a 128-entry file does not wrap the limit to zero.
    function automatic logic addr_in_range(input logic [6:0] addr, input int unsigned count);
        return ({25'd0, addr} < count);
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// REG_COUNT x 8-bit register file behind the SPI frame controller.
// Register 0 is the constant DEVICE_ID, register 1 is a read-only status slot
// with no storage (the live status is substituted by the controller), registers 2.. are writable.
// Read-only entries have no storage, so writes addressed to them are dropped here.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset (writable regs -> 8'h00)
//   i_wr_en          write enable, one cycle
//   i_wr_addr        write address
//   i_wr_data        write data
//   i_rd_addr        asynchronous read address
//   o_rd_data        register contents at i_rd_addr
//   o_regs_flat      all registers, reg n at [8n+7:8n]
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int unsigned REG_COUNT = 8,
    parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [$clog2(REG_COUNT)-1:0] i_wr_addr,
    input  logic [7:0]                   i_wr_data,
    input  logic [$clog2(REG_COUNT)-1:0] i_rd_addr,
    output logic [7:0]                   o_rd_data,
    output logic [REG_COUNT*8-1:0]       o_regs_flat
);

    localparam int unsigned AW = $clog2(REG_COUNT);

    logic [7:0] regs_s [REG_COUNT];

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
        if (g == REG_ID) begin : g_id
            assign regs_s[g] = DEVICE_ID;
        end else if (g == REG_STATUS) begin : g_ro
            assign regs_s[g] = 8'h00;
        end else begin : g_rw
            logic [7:0] val_r;

            // Storage for one writable register.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    val_r <= 8'h00;
                end else if (i_wr_en && (i_wr_addr == AW'(g))) begin
                    val_r <= i_wr_data;
                end else begin
                    val_r <= val_r;
                end
            end

            assign regs_s[g] = val_r;
        end

        assign o_regs_flat[8*g +: 8] = regs_s[g];
    end

    assign o_rd_data = regs_s[i_rd_addr];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller behind a byte-level SPI slave. Each CS-framed
// transaction is a command byte (bit7 = write, bits[6:0] = start address)
// followed by data bytes handled with an auto-incrementing, wrapping pointer.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_cs_active      synchronised CS level, 1 = frame in progress
//   i_rx_valid       one-cycle strobe, i_rx_data holds a complete byte
//   i_rx_data        received byte
//   i_status         live status, readable at register 1
//   o_tx_data        byte shifted out on the next byte slot
//   o_wr_strobe      one-cycle pulse per accepted register write
//   o_wr_addr        address of that write
//   o_regs_flat      all registers, reg n at [8n+7:8n]
//   o_led            register 2 bit 0
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned REG_COUNT = 8,
    parameter logic [7:0]  DEVICE_ID = 8'hA5,
    parameter logic [7:0]  CMD_ACK   = 8'h3C
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cs_active,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_data,
    input  logic [7:0]                   i_status,
    output logic [7:0]                   o_tx_data,
    output logic                         o_wr_strobe,
    output logic [$clog2(REG_COUNT)-1:0] o_wr_addr,
    output logic [REG_COUNT*8-1:0]       o_regs_flat,
    output logic                         o_led
);

    localparam int unsigned   AW       = $clog2(REG_COUNT);
    localparam logic [AW-1:0] FIRST_WR = AW'(REG_LED);

    state_e        state_r;
    state_e        state_next_s;
    logic          cs_r;
    logic [AW-1:0] ptr_r;
    logic [AW-1:0] ptr_next_s;
    logic [7:0]    tx_r;
    logic [7:0]    tx_next_s;
    logic          strobe_r;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_r;
    logic [AW-1:0] wr_addr_next_s;
    logic [AW-1:0] rd_addr_s;
    logic [7:0]    rd_data_s;
    logic [7:0]    rd_mux_s;
    logic [REG_COUNT*8-1:0] regs_flat_s;

    spi_reg_file #(
        .REG_COUNT (REG_COUNT),
        .DEVICE_ID (DEVICE_ID)
    ) u_reg_file (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (wr_en_s),
        .i_wr_addr   (ptr_r),
        .i_wr_data   (i_rx_data),
        .i_rd_addr   (rd_addr_s),
        .o_rd_data   (rd_data_s),
        .o_regs_flat (regs_flat_s)
    );

    // Register 1 is not stored: the live status is sampled when the TX byte is loaded.
    always_comb begin
        if (rd_addr_s == AW'(REG_STATUS)) begin
            rd_mux_s = i_status;
        end else begin
            rd_mux_s = rd_data_s;
        end
    end

    // Next-state, pointer, TX byte and write-port decode.
    always_comb begin
        state_next_s   = state_r;
        ptr_next_s     = ptr_r;
        tx_next_s      = tx_r;
        wr_en_s        = 1'b0;
        wr_addr_next_s = wr_addr_r;
        rd_addr_s      = ptr_r + 1'b1;

        if (!i_cs_active) begin
            // CS low wins over any byte strobe in the same cycle.
            state_next_s = ST_IDLE;
            tx_next_s    = CMD_ACK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Only a fresh 0->1 edge opens a frame; a CS already high
                    // out of reset is ignored until it cycles.
                    if (!cs_r) begin
                        state_next_s = ST_CMD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    rd_addr_s = i_rx_data[AW-1:0];
                    if (!i_rx_valid) begin
                        state_next_s = ST_CMD;
                    end else if (!addr_in_range(i_rx_data[6:0], REG_COUNT)) begin
                        state_next_s = ST_DISCARD;
                        tx_next_s    = TX_DISCARD;
                    end else if (i_rx_data[CMD_WR_BIT]) begin
                        state_next_s = ST_WRITE;
                        ptr_next_s   = i_rx_data[AW-1:0];
                        tx_next_s    = CMD_ACK;
                    end else begin
                        state_next_s = ST_READ;
                        ptr_next_s   = i_rx_data[AW-1:0];
                        tx_next_s    = rd_mux_s;
                    end
                end
                ST_WRITE: begin
                    if (i_rx_valid) begin
                        if (ptr_r >= FIRST_WR) begin
                            wr_en_s        = 1'b1;
                            wr_addr_next_s = ptr_r;
                        end else begin
                            wr_en_s        = 1'b0;
                        end
                        tx_next_s  = i_rx_data;
                        ptr_next_s = ptr_r + 1'b1;
                    end else begin
                        ptr_next_s = ptr_r;
                    end
                end
                ST_READ: begin
                    // rd_addr_s already points one past ptr_r, wrapping naturally.
                    if (i_rx_valid) begin
                        ptr_next_s = ptr_r + 1'b1;
                        tx_next_s  = rd_mux_s;
                    end else begin
                        ptr_next_s = ptr_r;
                    end
                end
                ST_DISCARD: begin
                    tx_next_s = TX_DISCARD;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    tx_next_s    = CMD_ACK;
                end
            endcase
        end
    end

    // State, CS history and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cs_r      <= 1'b1;
            ptr_r     <= {AW{1'b0}};
            tx_r      <= CMD_ACK;
            strobe_r  <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            cs_r      <= i_cs_active;
            ptr_r     <= ptr_next_s;
            tx_r      <= tx_next_s;
            strobe_r  <= wr_en_s;
            wr_addr_r <= wr_addr_next_s;
        end
    end

    assign o_tx_data   = tx_r;
    assign o_wr_strobe = strobe_r;
    assign o_wr_addr   = wr_addr_r;
    assign o_regs_flat = regs_flat_s;
    assign o_led       = regs_flat_s[8*REG_LED];

endmodule
